// File: rtl/vga2_fb_arbiter_if.sv
// ----------------------------------------------------------------------------
// vga2_fb_arbiter_if
//
// Bundles the pixel-writer handshake and the framebuffer RAM bus used by
// vga2_fb_arbiter.
//
// Handshake: the writer holds wr_valid and its payload (wr_addr_h, wr_addr_v,
// wr_color) stable; one pixel transfers on each rising clock edge where
// wr_valid and wr_ready are both high. wr_ready never depends on wr_valid.
//
// Signals:
//   wr_valid   writer offers a pixel
//   wr_ready   arbiter FIFO can accept a pixel
//   wr_addr_h  writer pixel column
//   wr_addr_v  writer pixel row
//   wr_color   writer {r,g,b}
//   mem_addr   RAM address (registered by the arbiter)
//   mem_we     RAM write enable (registered by the arbiter)
//   mem_wdata  RAM write data (registered by the arbiter)
//   mem_rdata  RAM read data, valid the cycle after mem_addr is presented
//
// Modports:
//   slave  - the arbiter: accepts writer pixels and drives the RAM bus
//   master - the environment: writer source plus the RAM itself
// ----------------------------------------------------------------------------
interface vga2_fb_arbiter_if #(
    parameter int HAddrSize   = 11,
    parameter int VAddrSize   = 11,
    parameter int MemAddrSize = 19
);
    logic                   wr_valid;
    logic                   wr_ready;
    logic [HAddrSize-1:0]   wr_addr_h;
    logic [VAddrSize-1:0]   wr_addr_v;
    logic [2:0]             wr_color;
    logic [MemAddrSize-1:0] mem_addr;
    logic                   mem_we;
    logic [2:0]             mem_wdata;
    logic [2:0]             mem_rdata;

    modport slave (
        input  wr_valid, wr_addr_h, wr_addr_v, wr_color, mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output wr_valid, wr_addr_h, wr_addr_v, wr_color, mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga2_fb_arbiter.sv
// ----------------------------------------------------------------------------
// vga2_fb_arbiter
//
// Shares one single-port, synchronous-read framebuffer RAM (3 bits/pixel)
// between the VGA2 scan-out path and a pixel writer. The display owns the RAM
// whenever disp_active is high. Writer pixels are buffered in a small FIFO and
// drained only in blanking cycles. A full-framebuffer clear can be requested;
// it also only uses blanking cycles and takes precedence over FIFO draining.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        asynchronous, active-low reset
//   disp_active  display address is a visible pixel
//   disp_addr_h  display pixel column
//   disp_addr_v  display pixel row
//   disp_color   {r,g,b} of a display read; appears two clocks after the
//                display address is presented on mem_addr
//   clear_req    single-cycle pulse: start clearing the framebuffer to 0
//   clear_busy   clear in progress
//   fifo_level   number of buffered writer pixels
//   state_dbg    current FSM state (0 = IDLE, 1 = CLEAR)
//   bus          writer handshake and RAM bus (slave modport)
// ----------------------------------------------------------------------------
module vga2_fb_arbiter #(
    parameter int HAddrSize    = 11,
    parameter int VAddrSize    = 11,
    parameter int HVisibleArea = 800,
    parameter int VVisibleArea = 600,
    parameter int MemAddrSize  = 19,
    parameter int FifoLog      = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 disp_active,
    input  logic [HAddrSize-1:0] disp_addr_h,
    input  logic [VAddrSize-1:0] disp_addr_v,
    output logic [2:0]           disp_color,
    input  logic                 clear_req,
    output logic                 clear_busy,
    output logic [FifoLog:0]     fifo_level,
    output logic                 state_dbg,
    vga2_fb_arbiter_if.slave     bus
);

    localparam int Depth = 1 << FifoLog;
    localparam logic [FifoLog:0]       DepthLvl = (FifoLog+1)'(Depth);
    localparam logic [MemAddrSize-1:0] LastAddr =
        MemAddrSize'(HVisibleArea * VVisibleArea - 1);
    localparam logic [HAddrSize-1:0]   HLimit   = HAddrSize'(HVisibleArea);
    localparam logic [VAddrSize-1:0]   VLimit   = VAddrSize'(VVisibleArea);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // The linear address is computed once at push time so the drain path is
    // a plain register load.
    typedef struct packed {
        logic                   ok;     // coordinates inside the visible area
        logic [MemAddrSize-1:0] addr;
        logic [2:0]             color;
    } fifo_entry_t;

    function automatic logic [MemAddrSize-1:0] lin_addr(
        input logic [HAddrSize-1:0] h,
        input logic [VAddrSize-1:0] v
    );
        return MemAddrSize'(v) * MemAddrSize'(HVisibleArea) + MemAddrSize'(h);
    endfunction

    state_t                 state;
    state_t                 state_next;
    logic [MemAddrSize-1:0] clr_cnt;
    logic                   clr_write;
    logic                   clr_last;
    logic                   pop;
    logic                   push;
    logic                   ready;
    logic                   ready_en;
    logic [FifoLog-1:0]     wr_ptr;
    logic [FifoLog-1:0]     rd_ptr;
    fifo_entry_t            fifo_mem [Depth];
    fifo_entry_t            push_entry;
    fifo_entry_t            head;
    logic [MemAddrSize-1:0] disp_lin;
    logic                   rd_q1;
    logic                   rd_q2;

    // ------------------------------------------------------------------------
    // FSM: state register (also owns the clear counter)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && clear_req) begin
                clr_cnt <= '0;
            end else if (clr_write) begin
                clr_cnt <= clr_cnt + MemAddrSize'(1);
            end
        end
    end

    // FSM: next state. A clear_req while already clearing is ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear_req) state_next = CLEAR;
            CLEAR:   if (clr_last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs. Display wins; clearing wins over draining the FIFO.
    always_comb begin
        clear_busy = (state == CLEAR);
        state_dbg  = state;
        clr_write  = (state == CLEAR) && !disp_active;
        clr_last   = clr_write && (clr_cnt == LastAddr);
        pop        = (state == IDLE) && !disp_active && (fifo_level != '0);
    end

    // ------------------------------------------------------------------------
    // Writer FIFO
    // ------------------------------------------------------------------------
    // ready_en keeps wr_ready low until the first clock after reset release.
    assign ready        = ready_en && (fifo_level != DepthLvl);
    assign bus.wr_ready = ready;
    assign push         = bus.wr_valid && ready;
    assign head         = fifo_mem[rd_ptr];

    always_comb begin
        push_entry.ok    = (bus.wr_addr_h < HLimit) && (bus.wr_addr_v < VLimit);
        push_entry.addr  = lin_addr(bus.wr_addr_h, bus.wr_addr_v);
        push_entry.color = bus.wr_color;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_en   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + FifoLog'(1);
            if (pop)  rd_ptr <= rd_ptr + FifoLog'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (FifoLog+1)'(1);
                2'b01:   fifo_level <= fifo_level - (FifoLog+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // RAM bus and display return path
    // ------------------------------------------------------------------------
    assign disp_lin = lin_addr(disp_addr_h, disp_addr_v);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= 3'b000;
        end else if (disp_active) begin
            bus.mem_addr  <= disp_lin;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= 3'b000;
        end else if (clr_write) begin
            bus.mem_addr  <= clr_cnt;
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= 3'b000;
        end else if (pop) begin
            // Out-of-range pixels are consumed here without a RAM write.
            bus.mem_addr  <= head.addr;
            bus.mem_we    <= head.ok;
            bus.mem_wdata <= head.color;
        end else begin
            bus.mem_we <= 1'b0;
        end
    end

    // rd_q1 marks a display read on the bus; rd_q2 marks that mem_rdata now
    // holds the data of that read, so disp_color captures it one edge later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q1      <= 1'b0;
            rd_q2      <= 1'b0;
            disp_color <= 3'b000;
        end else begin
            rd_q1      <= disp_active;
            rd_q2      <= rd_q1;
            disp_color <= rd_q2 ? bus.mem_rdata : 3'b000;
        end
    end

endmodule

// File: tb/tb_vga2_fb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vga2_fb_arbiter
//
// Bench for vga2_fb_arbiter with a 800x12 visible area (same line stride as
// the default, fewer lines so a full clear stays short). A behavioural
// synchronous-read RAM sits on the memory bus. Expected RAM writes are queued
// as {addr, data} when stimulus is issued; a monitor on the falling edge pops
// and compares every mem_we cycle.
// ----------------------------------------------------------------------------
module tb_vga2_fb_arbiter;

    localparam int HA    = 11;
    localparam int VA    = 11;
    localparam int HV    = 800;
    localparam int VV    = 12;
    localparam int MA    = 19;
    localparam int FL    = 2;
    localparam int TOTAL = HV * VV;
    localparam int W     = MA + 3;

    logic          clock;
    logic          reset;
    logic          disp_active;
    logic [HA-1:0] disp_addr_h;
    logic [VA-1:0] disp_addr_v;
    logic [2:0]    disp_color;
    logic          clear_req;
    logic          clear_busy;
    logic [FL:0]   fifo_level;
    logic          state_dbg;

    vga2_fb_arbiter_if #(.HAddrSize(HA), .VAddrSize(VA), .MemAddrSize(MA)) bus ();

    vga2_fb_arbiter #(
        .HAddrSize(HA), .VAddrSize(VA), .HVisibleArea(HV), .VVisibleArea(VV),
        .MemAddrSize(MA), .FifoLog(FL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .disp_active (disp_active),
        .disp_addr_h (disp_addr_h),
        .disp_addr_v (disp_addr_v),
        .disp_color  (disp_color),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .fifo_level  (fifo_level),
        .state_dbg   (state_dbg),
        .bus         (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- RAM model ----------------
    logic [2:0] ram [0:TOTAL-1];
    logic       fill;

    always @(posedge clock) begin
        if (fill) begin
            for (int i = 0; i < TOTAL; i++) ram[i] <= 3'b111;
        end else if (bus.mem_we && int'(bus.mem_addr) < TOTAL) begin
            ram[int'(bus.mem_addr)] <= bus.mem_wdata;
        end
        bus.mem_rdata <= (int'(bus.mem_addr) < TOTAL) ? ram[int'(bus.mem_addr)] : 3'b000;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_fill();
        fill = 1'b1;
        tick();
        fill = 1'b0;
    endtask

    // Offers one pixel and returns after the transfer edge.
    task automatic push(input int h, input int v, input logic [2:0] c,
                        input int exp_addr, input bit expect_write);
        int n;
        bus.wr_valid  = 1'b1;
        bus.wr_addr_h = HA'(h);
        bus.wr_addr_v = VA'(v);
        bus.wr_color  = c;
        if (expect_write) exp_q.push_back({MA'(exp_addr), c});
        n = 0;
        while (!bus.wr_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready", {31'b0, bus.wr_ready}, 32'd1);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    // Display read: address goes out on the first edge, disp_color carries the
    // data two edges after that.
    task automatic disp_read(input int h, input int v, input int exp_addr,
                             input logic [2:0] exp_color);
        disp_active = 1'b1;
        disp_addr_h = HA'(h);
        disp_addr_v = VA'(v);
        tick();
        disp_active = 1'b0;
        check("rd_addr", {13'b0, bus.mem_addr}, exp_addr);
        check("rd_we", {31'b0, bus.mem_we}, 32'd0);
        tick();
        check("rd_color_early", {29'b0, disp_color}, 32'd0);
        tick();
        check("rd_color", {29'b0, disp_color}, {29'b0, exp_color});
    endtask

    task automatic queue_clear();
        for (int i = 0; i < TOTAL; i++) exp_q.push_back({MA'(i), 3'b000});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_level != 0) && n < 40) begin
            tick();
            n++;
        end
        tick();
        check(name, exp_q.size(), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic last_active = 1'b0;

    always @(negedge clock) begin
        if (reset && bus.mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mem_write: unexpected write addr=%0d data=%0b",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (e !== {bus.mem_addr, bus.mem_wdata} || last_active) begin
                    errors++;
                    $display("FAIL mem_write: got addr=%0d data=%0b active=%0b, expected addr=%0d data=%0b active=0",
                             bus.mem_addr, bus.mem_wdata, last_active, e[W-1:3], e[2:0]);
                end
            end
        end
        last_active = disp_active;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        int nz;
        reset         = 1'b1;
        fill          = 1'b0;
        disp_active   = 1'b0;
        disp_addr_h   = '0;
        disp_addr_v   = '0;
        clear_req     = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr_h = '0;
        bus.wr_addr_v = '0;
        bus.wr_color  = 3'b000;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_disp_color", {29'b0, disp_color}, 32'd0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", {13'b0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", {29'b0, bus.mem_wdata}, 32'd0);
        check("rst_fifo_level", {29'b0, fifo_level}, 32'd0);
        check("rst_clear_busy", {31'b0, clear_busy}, 32'd0);
        check("rst_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
        tick();
        tick();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("wr_ready_pre", {31'b0, bus.wr_ready}, 32'd0);
        tick();
        check("wr_ready_post", {31'b0, bus.wr_ready}, 32'd1);

        // Single write in blanking, then read it back
        push(5, 2, 3'b101, 1605, 1'b1);
        check("lat_we_edge1", {31'b0, bus.mem_we}, 32'd0);
        tick();
        check("lat_we_edge2", {31'b0, bus.mem_we}, 32'd1);
        check("lat_addr", {13'b0, bus.mem_addr}, 32'd1605);
        check("lat_wdata", {29'b0, bus.mem_wdata}, 32'h5);
        disp_read(5, 2, 1605, 3'b101);

        // Writes during the visible area stay buffered
        disp_active = 1'b1;
        push(10, 1, 3'b001, 810, 1'b1);
        push(11, 1, 3'b010, 811, 1'b1);
        push(799, 11, 3'b011, 9599, 1'b1);
        push(10, 1, 3'b100, 810, 1'b1);
        check("vis_level", {29'b0, fifo_level}, 32'd4);
        check("vis_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
        tick();
        check("vis_level_hold", {29'b0, fifo_level}, 32'd4);
        disp_active = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            tick();
            check("drain_level", {29'b0, fifo_level}, k);
        end
        wait_drain("drain_done");

        // Out-of-range coordinates are accepted but never written
        push(800, 0, 3'b111, 0, 1'b0);
        push(0, 12, 3'b110, 0, 1'b0);
        repeat (3) tick();
        check("oor_level", {29'b0, fifo_level}, 32'd0);

        // Simultaneous push and pop keep the level
        disp_active = 1'b1;
        push(20, 3, 3'b001, 2420, 1'b1);
        push(21, 3, 3'b010, 2421, 1'b1);
        check("pp_level_start", {29'b0, fifo_level}, 32'd2);
        disp_active = 1'b0;
        push(22, 3, 3'b011, 2422, 1'b1);
        check("pp_level", {29'b0, fifo_level}, 32'd2);
        push(23, 3, 3'b100, 2423, 1'b1);
        check("pp_level", {29'b0, fifo_level}, 32'd2);
        push(24, 3, 3'b101, 2424, 1'b1);
        check("pp_level", {29'b0, fifo_level}, 32'd2);
        wait_drain("pp_drain");

        // Full clear in blanking, with an ignored clear_req mid-way
        do_fill();
        queue_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clr_busy_start", {31'b0, clear_busy}, 32'd1);
        cnt = 0;
        while (clear_busy && cnt < 20000) begin
            clear_req = (cnt == 500);
            cnt++;
            tick();
        end
        clear_req = 1'b0;
        check("clr_busy_cycles", cnt, TOTAL);
        wait_drain("clr_writes");
        nz = 0;
        for (int i = 0; i < TOTAL; i++) if (ram[i] !== 3'b000) nz++;
        check("clr_all_zero", nz, 32'd0);
        disp_read(799, 11, 9599, 3'b000);

        // Clear interleaved with display, writer pixels held until it ends
        do_fill();
        queue_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt = 0;
        while (clear_busy && cnt < 30000) begin
            disp_active   = cnt[0];
            bus.wr_valid  = (cnt == 10) || (cnt == 11);
            bus.wr_addr_h = (cnt == 10) ? HA'(30) : HA'(31);
            bus.wr_addr_v = VA'(4);
            bus.wr_color  = (cnt == 10) ? 3'b011 : 3'b110;
            if (cnt == 10) exp_q.push_back({MA'(3230), 3'b011});
            if (cnt == 11) exp_q.push_back({MA'(3231), 3'b110});
            if (cnt == 100) check("ilv_fifo_hold", {29'b0, fifo_level}, 32'd2);
            cnt++;
            tick();
        end
        bus.wr_valid = 1'b0;
        disp_active  = 1'b0;
        check("ilv_clear_done", {31'b0, clear_busy}, 32'd0);
        wait_drain("ilv_writes");
        check("ilv_ram_first", {29'b0, ram[0]}, 32'd0);
        check("ilv_ram_last", {29'b0, ram[TOTAL-1]}, 32'd0);
        check("ilv_ram_px0", {29'b0, ram[3230]}, 32'h3);
        check("ilv_ram_px1", {29'b0, ram[3231]}, 32'h6);

        // Reset in the middle of a clear, counter at 1000
        do_fill();
        queue_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        push(40, 5, 3'b001, 4040, 1'b1);
        push(41, 5, 3'b010, 4041, 1'b1);
        repeat (998) tick();
        check("mid_level", {29'b0, fifo_level}, 32'd2);
        check("mid_we", {31'b0, bus.mem_we}, 32'd1);
        check("mid_addr", {13'b0, bus.mem_addr}, 32'd999);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_busy", {31'b0, clear_busy}, 32'd0);
        check("mid_rst_level", {29'b0, fifo_level}, 32'd0);
        check("mid_rst_we", {31'b0, bus.mem_we}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("mid_ram_0", {29'b0, ram[0]}, 32'd0);
        check("mid_ram_998", {29'b0, ram[998]}, 32'd0);
        check("mid_ram_1000", {29'b0, ram[1000]}, 32'h7);
        check("mid_ram_last", {29'b0, ram[TOTAL-1]}, 32'h7);
        check("mid_idle_busy", {31'b0, clear_busy}, 32'd0);
        check("mid_idle_level", {29'b0, fifo_level}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
